pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGES, default 4, meaning the number of pipeline latches (index 0 = IF/ID), legal range 2..8.
REQ-002 SHALL have parameter MEM_STAGE, default 2, meaning the latch index whose output drives the data-memory request, legal range 1..NSTAGES-1.
REQ-003 SHALL have port CLK  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ihit  in  1  instruction fetch completed this cycle.
REQ-006 SHALL have port dhit  in  1  data access completed this cycle.
REQ-007 SHALL have port mem_req  in  1  latch MEM_STAGE holds a load or store.
REQ-008 SHALL have port load_use  in  1  ID detects a load-use hazard.
REQ-009 SHALL have port redirect  in  1  branch or jump resolved taken.
REQ-010 SHALL have port redirect_stage  in  $clog2(NSTAGES)  number of youngest latches to flush on redirect.
REQ-011 SHALL have port halt_in  in  1  halt decoded from latch 0 output.
REQ-012 SHALL have port stage_wen  out  NSTAGES  per-latch write enable.
REQ-013 SHALL have port stage_flush  out  NSTAGES  per-latch bubble insert; meaningful only with wen.
REQ-014 SHALL have port stage_valid  out  NSTAGES  per-latch occupancy.
REQ-015 SHALL have port pc_en  out  1  PC update enable.
REQ-016 SHALL have port halted  out  1  pipeline drained after halt.
REQ-017 SHALL have port stall_cnt  out  32  freeze-cycle counter.
REQ-018 SHALL have port bubble_cnt  out  32  load-use bubble counter.

Function
REQ-019 SHALL implement FSM states RUN, DRAIN and HALTED, where RUN -> DRAIN on halt_in & stage_valid[0] & !freeze, DRAIN -> HALTED when the drain counter reaches NSTAGES-1, and HALTED is sticky until reset.
REQ-020 SHALL define freeze = mem_req & stage_valid[MEM_STAGE] & !dhit, which forces all stage_wen=0 and pc_en=0 with no other effect.
REQ-021 SHALL apply the priority freeze > redirect > load_use > !ihit.
REQ-022 SHALL, on redirect without freeze, drive stage_wen all 1, stage_flush[i]=1 for i<redirect_stage, and pc_en=1.
REQ-023 SHALL, on load_use without freeze or redirect, drive stage_wen[0]=0, stage_wen[1]=1 with stage_flush[1]=1, stage_wen[i>=2]=1, and pc_en=0.
REQ-024 SHALL, on !ihit with no higher-priority event, drive stage_wen all 1, stage_flush[0]=1, and pc_en=0.
REQ-025 SHALL otherwise drive stage_wen all 1, stage_flush 0, and pc_en=1.
REQ-026 SHALL, in DRAIN, drive pc_en=0 and stage_flush[0]=1, honour freeze, and increment the drain counter only on non-freeze cycles.
REQ-027 SHALL, in HALTED, drive stage_wen=0 and pc_en=0, with halted=1 combinationally from the state.
REQ-028 SHALL update valid when stage_wen[i]=1 as valid[i] <= !stage_flush[i] & (i==0 ? 1 : valid[i-1]), and hold it otherwise.
REQ-029 SHALL, when redirect and halt_in coincide, ignore the halt because latch 0 is flushed.
REQ-030 SHALL, when redirect_stage is 0, flush nothing.
REQ-031 SHALL have zero-cycle combinational latency from inputs to stage_wen, stage_flush and pc_en.

Reset
REQ-032 SHALL, while nRST=0, set state=RUN, stage_valid=0, drain counter=0, stall_cnt=0, bubble_cnt=0 and halted=0.
REQ-033 SHALL, on reset mid-freeze or mid-drain, abandon the operation immediately with no residual state.
REQ-034 SHALL make the first rising edge after reset release behave as RUN with an empty pipeline.

Configuration
REQ-035 SHALL, with PIPE_CTRL_PERF_EN defined, increment stall_cnt each freeze cycle and bubble_cnt each load-use bubble, both saturating at 32'hFFFF_FFFF.
REQ-036 SHALL, with PIPE_CTRL_PERF_EN undefined, tie stall_cnt and bubble_cnt to 0 and instantiate no counter flops.

Verification
REQ-037 SHALL cover fill: NSTAGES=4, ihit=1 for 4 cycles -> stage_valid 0001,0011,0111,1111.
REQ-038 SHALL cover freeze: full pipe, mem_req=1, dhit=0 for 3 cycles -> stage_wen=0000, pc_en=0, valid unchanged, stall_cnt=3 (PERF_EN); dhit=1 -> wen=1111.
REQ-039 SHALL cover load-use: full pipe, load_use=1 for 1 cycle -> wen=1110, flush=0010, next valid=1101, bubble_cnt=1.
REQ-040 SHALL cover redirect: full pipe, redirect=1, redirect_stage=2 -> flush=0011, pc_en=1, next valid=1100.
REQ-041 SHALL cover halt: halt_in=1 in RUN -> DRAIN, 3 non-freeze cycles later halted=1, pc_en=0, wen=0000; a freeze during drain delays halted by exactly the freeze length.
REQ-042 SHALL cover async reset: nRST=0 mid-DRAIN -> halted=0, valid=0000, counters 0, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline latch controller: stall, flush, bubble and halt/drain sequencing.
// Define PIPE_CTRL_PERF_EN to build the saturating stall/bubble counters.
module pipe_ctrl #(
    parameter int NSTAGES   = 4,
    parameter int MEM_STAGE = 2
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       ihit,
    input  logic                       dhit,
    input  logic                       mem_req,
    input  logic                       load_use,
    input  logic                       redirect,
    input  logic [$clog2(NSTAGES)-1:0] redirect_stage,
    input  logic                       halt_in,
    output logic [NSTAGES-1:0]         stage_wen,
    output logic [NSTAGES-1:0]         stage_flush,
    output logic [NSTAGES-1:0]         stage_valid,
    output logic                       pc_en,
    output logic                       halted,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                bubble_cnt
);

    localparam int DW = $clog2(NSTAGES) + 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t             state, state_next;
    logic [DW-1:0]      drain_cnt, drain_cnt_next;
    logic               freeze;
    logic [NSTAGES-1:0] redirect_mask;
    logic [NSTAGES-1:0] valid_in;

    assign freeze        = mem_req & stage_valid[MEM_STAGE] & ~dhit;
    assign redirect_mask = ~({NSTAGES{1'b1}} << redirect_stage);
    assign valid_in      = {stage_valid[NSTAGES-2:0], 1'b1};
    assign halted        = (state == HALTED);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next     = state;
        drain_cnt_next = drain_cnt;
        stage_wen      = '1;
        stage_flush    = '0;
        pc_en          = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    stage_flush = redirect_mask;
                    pc_en       = 1'b1;
                end else if (load_use) begin
                    stage_wen[0] = 1'b0;
                    stage_flush  = NSTAGES'(2);
                end else if (!ihit) begin
                    stage_flush = NSTAGES'(1);
                end else begin
                    pc_en = 1'b1;
                end
                // A taken redirect squashes latch 0, so its halt never counts.
                if (halt_in && stage_valid[0] && !redirect && !freeze) begin
                    state_next     = DRAIN;
                    drain_cnt_next = '0;
                end
            end
            DRAIN: begin
                stage_flush = NSTAGES'(1);
                if (!freeze) begin
                    drain_cnt_next = drain_cnt + 1'b1;
                    if (drain_cnt_next == DW'(NSTAGES - 1))
                        state_next = HALTED;
                end
            end
            HALTED: stage_wen = '0;
            default: state_next = RUN;
        endcase
        // Freeze only gates the enables; flush values are don't-care when wen is low.
        if (freeze) begin
            stage_wen = '0;
            pc_en     = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= RUN;
            drain_cnt   <= '0;
            stage_valid <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            for (int i = 0; i < NSTAGES; i++)
                if (stage_wen[i])
                    stage_valid[i] <= ~stage_flush[i] & valid_in[i];
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic stall_event, bubble_event;

    assign stall_event  = freeze & (state != HALTED);
    assign bubble_event = (state == RUN) & ~freeze & ~redirect & load_use;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_event && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (bubble_event && bubble_cnt != 32'hFFFF_FFFF)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then random traffic against a
// behavioural model of the control rules (NSTAGES=4, MEM_STAGE=2).
module tb_pipe_ctrl;

    localparam int NS = 4;
    localparam int MS = 2;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef enum {M_RUN, M_DRAIN, M_HALTED} mode_t;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          ihit = 1'b0, dhit = 1'b0, mem_req = 1'b0, load_use = 1'b0;
    logic          redirect = 1'b0, halt_in = 1'b0;
    logic [1:0]    redirect_stage = 2'd0;
    logic [NS-1:0] stage_wen, stage_flush, stage_valid;
    logic          pc_en, halted;
    logic [31:0]   stall_cnt, bubble_cnt;

    int n_vec = 0;
    int n_err = 0;

    mode_t       m_mode = M_RUN;
    bit [NS-1:0] m_valid = '0;
    int          m_drained = 0;
    bit [31:0]   m_stall = 0, m_bubble = 0;

    pipe_ctrl #(.NSTAGES(NS), .MEM_STAGE(MS)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .load_use(load_use), .redirect(redirect), .redirect_stage(redirect_stage),
        .halt_in(halt_in), .stage_wen(stage_wen), .stage_flush(stage_flush),
        .stage_valid(stage_valid), .pc_en(pc_en), .halted(halted),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a negedge; returns just after the following negedge.
    task automatic step(input bit i_ihit, input bit i_dhit, input bit i_mem, input bit i_lu,
                        input bit i_rd, input bit [1:0] i_rs, input bit i_halt);
        bit          fz, ep;
        bit [NS-1:0] ew, ef, nv, prev;
        ihit = i_ihit; dhit = i_dhit; mem_req = i_mem; load_use = i_lu;
        redirect = i_rd; redirect_stage = i_rs; halt_in = i_halt;
        #1;
        fz = i_mem && m_valid[MS] && !i_dhit;
        ew = '1; ef = '0; ep = 1'b0;
        if (m_mode == M_HALTED || fz)  ew = '0;
        else if (m_mode == M_DRAIN)    ef = 4'b0001;
        else if (i_rd) begin
            for (int k = 0; k < int'(i_rs); k++) ef[k] = 1'b1;
            ep = 1'b1;
        end
        else if (i_lu) begin ew = 4'b1110; ef = 4'b0010; end
        else if (!i_ihit)              ef = 4'b0001;
        else                           ep = 1'b1;

        check("wen",    32'(stage_wen), 32'(ew));
        check("flush",  32'(stage_flush & ew), 32'(ef & ew));
        check("pc_en",  32'(pc_en), 32'(ep));
        check("valid",  32'(stage_valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(m_mode == M_HALTED));
        check("stall",  stall_cnt,  PERF ? m_stall  : 32'd0);
        check("bubble", bubble_cnt, PERF ? m_bubble : 32'd0);

        prev = {m_valid[NS-2:0], 1'b1};
        for (int k = 0; k < NS; k++)
            nv[k] = ew[k] ? (!ef[k] && prev[k]) : m_valid[k];

        @(posedge CLK);
        if (m_mode != M_HALTED && fz && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (m_mode == M_RUN && !fz && !i_rd && i_lu && m_bubble != 32'hFFFF_FFFF) m_bubble++;
        case (m_mode)
            M_RUN: if (i_halt && m_valid[0] && !i_rd && !fz) begin
                m_mode = M_DRAIN;
                m_drained = 0;
            end
            M_DRAIN: if (!fz) begin
                m_drained++;
                if (m_drained == NS - 1) m_mode = M_HALTED;
            end
            default: ;
        endcase
        m_valid = nv;
        @(negedge CLK);
    endtask

    task automatic run_normal(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 2'd0, 0);
    endtask

    // Asserts reset without waiting for an edge and checks the clear is immediate.
    task automatic do_reset();
        nRST = 1'b0;
        ihit = 0; dhit = 0; mem_req = 0; load_use = 0; redirect = 0; halt_in = 0;
        #2;
        check("rst_valid",  32'(stage_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_stall",  stall_cnt, 32'd0);
        check("rst_bubble", bubble_cnt, 32'd0);
        m_mode = M_RUN; m_valid = '0; m_drained = 0; m_stall = 0; m_bubble = 0;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        @(negedge CLK);
        do_reset();

        // Fill: valid 0001, 0011, 0111, 1111 on successive cycles.
        run_normal(4);
        check("fill_full", 32'(stage_valid), 32'hF);

        // Freeze three cycles, then the data access completes.
        for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 0, 2'd0, 0);
        check("frz_valid", 32'(stage_valid), 32'hF);
        check("frz_stall", stall_cnt, PERF ? 32'd3 : 32'd0);
        step(1, 1, 1, 0, 0, 2'd0, 0);

        // Load-use bubble; next cycle shows valid 1101.
        step(1, 0, 0, 1, 0, 2'd0, 0);
        check("lu_valid",  32'(stage_valid), 32'b1101);
        check("lu_bubble", bubble_cnt, PERF ? 32'd1 : 32'd0);
        run_normal(3);

        // Redirect flushing the two youngest latches, then redirect_stage 0.
        step(1, 0, 0, 0, 1, 2'd2, 0);
        check("rd_valid", 32'(stage_valid), 32'b1100);
        run_normal(3);
        step(1, 0, 0, 0, 1, 2'd0, 0);
        check("rd0_valid", 32'(stage_valid), 32'hF);

        // Halt coinciding with redirect is ignored.
        step(1, 0, 0, 0, 1, 2'd3, 1);
        step(1, 0, 0, 0, 0, 2'd0, 0);
        check("rd_halt", 32'(pc_en), 32'd1);
        run_normal(3);

        // Halt with a two-cycle freeze mid-drain: halted arrives two cycles late.
        step(1, 0, 0, 0, 0, 2'd0, 1);
        step(1, 0, 0, 0, 0, 2'd0, 0);
        step(1, 0, 1, 0, 0, 2'd0, 0);
        step(1, 0, 1, 0, 0, 2'd0, 0);
        check("drn_not_yet", 32'(halted), 32'd0);
        step(1, 0, 0, 0, 0, 2'd0, 0);
        check("drn_not_yet2", 32'(halted), 32'd0);
        step(1, 0, 0, 0, 0, 2'd0, 0);
        check("drn_halted", 32'(halted), 32'd1);
        step(1, 0, 0, 0, 0, 2'd0, 0);

        // Reset mid-drain.
        do_reset();
        run_normal(4);
        step(1, 0, 1, 0, 0, 2'd0, 0);
        step(1, 0, 0, 0, 0, 2'd0, 1);
        step(1, 0, 0, 0, 0, 2'd0, 0);
        do_reset();
        run_normal(2);

        // Random traffic with occasional halts and resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0 ||
                (m_mode == M_HALTED && $urandom_range(0, 3) == 0)) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)),
                     $urandom_range(0, 39) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
